// File: rtl/inst_mem_loader.sv
// Instruction memory with a streaming program loader and a single-cycle fetch port.
// A load fills the memory from address 0; RUN serves registered fetches.
module inst_mem_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         LoadStart,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadReady,
  input  logic         FetchEn,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         InstValid,
  output logic         Running,
  output logic [A:0]   LoadCount,
  output logic         LoadError
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [A-1:0] PTR_MAX = {A{1'b1}};
  localparam int DEPTH = 2 ** A;

  logic [1:0]   state_reg, state_next;
  logic [A-1:0] wr_ptr_reg, wr_ptr_next;
  logic [A:0]   count_reg, count_next;
  logic         error_reg, error_next;
  logic [W-1:0] inst_out_reg;
  logic         inst_valid_reg;

  logic         accept;
  logic         wr_en;
  logic         fetch_en;

  logic [W-1:0] mem [0:DEPTH-1];

  assign accept   = (state_reg == ST_LOAD) && LoadValid;
  // Reset wins over a word presented in the same cycle, so nothing is written.
  assign wr_en    = accept && !Reset;
  // A load request in RUN pre-empts a simultaneous fetch.
  assign fetch_en = (state_reg == ST_RUN) && FetchEn && !LoadStart;

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    error_next  = error_reg;
    case (state_reg)
      ST_IDLE, ST_RUN: begin
        if (LoadStart) begin
          state_next  = ST_LOAD;
          wr_ptr_next = '0;
          count_next  = '0;
          error_next  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          count_next = count_reg + (A+1)'(1);
          if (LoadLast) begin
            state_next = ST_RUN;
            if (wr_ptr_reg != PTR_MAX) begin
              wr_ptr_next = wr_ptr_reg + A'(1);
            end
          end else if (wr_ptr_reg == PTR_MAX) begin
            // Memory full without a terminating word: stop, keep the pointer saturated.
            state_next = ST_IDLE;
            error_next = 1'b1;
          end else begin
            wr_ptr_next = wr_ptr_reg + A'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      error_reg  <= error_next;
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= LoadData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      inst_out_reg   <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      inst_valid_reg <= fetch_en;
      if (fetch_en) begin
        inst_out_reg <= mem[InstAddress];
      end
    end
  end

  assign LoadReady = (state_reg == ST_LOAD);
  assign Running   = (state_reg == ST_RUN);
  assign LoadCount = count_reg;
  assign LoadError = error_reg;
  assign InstOut   = inst_out_reg;
  assign InstValid = inst_valid_reg;

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter A, default 10: instruction address width; memory depth is 2**A words.
REQ-002 SHALL have parameter W, default 9: instruction word width.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port LoadStart, input, 1: request to begin a program load at address 0.
REQ-006 SHALL have port LoadValid, input, 1: LoadData holds a valid word.
REQ-007 SHALL have port LoadData, input, W: program word to write.
REQ-008 SHALL have port LoadLast, input, 1: qualifies LoadData as the final word of the program.
REQ-009 SHALL have port LoadReady, output, 1: block accepts a word this cycle.
REQ-010 SHALL have port FetchEn, input, 1: fetch request for InstAddress.
REQ-011 SHALL have port InstAddress, input, A: fetch address.
REQ-012 SHALL have port InstOut, output, W: registered instruction word.
REQ-013 SHALL have port InstValid, output, 1: InstOut was updated by a fetch in the previous cycle.
REQ-014 SHALL have port Running, output, 1: block is in RUN state.
REQ-015 SHALL have port LoadCount, output, A+1: number of words written by the current or most recent load.
REQ-016 SHALL have port LoadError, output, 1: sticky overflow flag for the most recent load.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, LOAD, RUN.
REQ-018 SHALL hold 2**A x W storage with one write port (loader) and one synchronous read port (fetch); array contents are not cleared by Reset.
REQ-019 SHALL move IDLE->LOAD or RUN->LOAD on LoadStart=1, clear the write pointer and LoadCount to 0, and clear LoadError.
REQ-020 SHALL ignore LoadStart while in LOAD.
REQ-021 SHALL drive LoadReady=1 only in LOAD state; 0 otherwise.
REQ-022 SHALL accept a word when LoadValid&LoadReady: write LoadData at the write pointer, then increment the pointer and LoadCount by 1.
REQ-023 SHALL move LOAD->RUN on the cycle after an accepted word with LoadLast=1.
REQ-024 SHALL treat an accepted word at pointer 2**A-1 with LoadLast=0 as overflow: word is written, LoadCount becomes 2**A, LoadError is set, and the state moves to IDLE; the pointer does not wrap.
REQ-025 SHALL, in RUN with FetchEn=1, load InstOut with mem[InstAddress] and set InstValid=1 at the next rising edge (1-cycle latency).
REQ-026 SHALL, in RUN with FetchEn=0, hold InstOut and drive InstValid=0 at the next edge.
REQ-027 SHALL ignore FetchEn outside RUN: InstOut holds, InstValid=0.
REQ-028 SHALL give LoadStart priority over FetchEn when both are asserted in RUN: no fetch occurs, InstValid=0 next cycle.
REQ-029 SHALL drive Running=1 only in RUN.
REQ-030 SHALL leave the contents of never-written addresses undefined; fetches of those addresses have undefined InstOut but correct InstValid timing.

Reset
REQ-031 SHALL, on Reset=1 at a rising edge, force state IDLE, InstOut=0, InstValid=0, LoadReady=0, Running=0, LoadCount=0, LoadError=0, write pointer=0.
REQ-032 SHALL, when Reset occurs mid-load, abort the load; words already written stay in memory; a new LoadStart is required.
REQ-033 SHALL give Reset priority over all other inputs in the same cycle.

Verification
REQ-034 SHALL cover: Reset, LoadStart, 4 words 0x1A5,0x0F0,0x003,0x1FF (last with LoadLast) -> LoadCount=4, Running=1; fetch addr 0..3 -> InstOut same values one cycle later, InstValid=1 each.
REQ-035 SHALL cover: LoadValid toggled 1/0 every cycle during load -> only handshaken words written, LoadCount counts only accepted words.
REQ-036 SHALL cover: with A=3, 8 words without LoadLast -> LoadError=1, LoadCount=8, state IDLE, LoadReady=0; 9th LoadValid ignored.
REQ-037 SHALL cover: LoadStart and FetchEn together in RUN -> LoadReady=1 next cycle, InstValid=0, InstOut unchanged.
REQ-038 SHALL cover: Reset after 2 of 4 words -> all outputs at reset values; after reload of 1 word 0x055 with LoadLast, fetch addr 1 returns the earlier word from the aborted load.
REQ-039 SHALL cover: FetchEn in IDLE and in LOAD -> InstValid stays 0, InstOut holds.
